bubble_sorter: RTL and testbench
================================

BUBBLE_SORTER -- requirements
Module: bubble_sorter

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the element width in bits.
REQ-002 The block SHALL have parameter DESCENDING, default 0: 0 sorts ascending, 1 sorts descending; comparisons are unsigned.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a request to sort the current inputs.
REQ-006 The block SHALL have ports first_reg, second_reg, third_reg, fourth_reg, input, W bits each: the four unsorted elements from the upstream load datapath.
REQ-007 The block SHALL have ports out0..out3, output, W bits each: the sorted elements, with out0 the smallest in ascending mode.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a sort is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-010 The block SHALL have port swap_count, output, 3 bits: the number of swaps performed in the last sort (0..6).

Function
REQ-011 The block SHALL implement states IDLE, COMPARE and DONE.
REQ-012 In IDLE with start=1 at edge E, the block SHALL capture first..fourth_reg into out0..out3, clear swap_count, set busy=1 and enter COMPARE with pass=0, idx=0.
REQ-013 In each COMPARE cycle, the block SHALL compare element idx with element idx+1 and swap them at the next edge if they are out of order; swap_count SHALL increment on each swap.
REQ-014 Equal elements SHALL NOT be swapped, so the sort is stable.
REQ-015 Pass p SHALL compare idx 0..(2-p), and pass p SHALL go from 0 to 2, giving 3+2+1 = 6 compare cycles at edges E+1..E+6.
REQ-016 After the final compare, the block SHALL be in DONE for exactly one cycle, with done=1, busy=0, and out0..out3 sorted.
REQ-017 From DONE, the block SHALL return to IDLE at the next edge; start asserted during DONE SHALL be ignored.
REQ-018 The latency from the start-accept edge to done high SHALL be 6 edges without early exit.
REQ-019 start SHALL be ignored while busy=1; input changes after capture SHALL NOT affect the sort in progress.
REQ-020 out0..out3 and swap_count SHALL hold their values from the end of a sort until the next accepted start.
REQ-021 start held high continuously SHALL begin a new sort on the first IDLE cycle after DONE (back-to-back period of 8 cycles).

Reset
REQ-022 When rst_n=0, the block SHALL asynchronously force state IDLE, out0..out3=0, swap_count=0, busy=0, done=0, pass=0 and idx=0.
REQ-023 A reset asserted mid-sort SHALL abort the sort with no done pulse; the block SHALL accept start on the first edge after rst_n rises.

Configuration
REQ-024 When macro BUBBLE_SORTER_EARLY_EXIT_EN is defined, a pass that completes with zero swaps SHALL go directly to DONE; already-sorted input SHALL then give done after 3 compare cycles.
REQ-025 When BUBBLE_SORTER_EARLY_EXIT_EN is undefined, the block SHALL always perform all 6 compare cycles regardless of data.

Structure
REQ-026 Package sort_pkg SHALL hold the state enum typedef (IDLE, COMPARE, DONE), constant NUM_ELEM=4, and the pass and idx widths.
REQ-027 Sub-module compare_swap SHALL be purely combinational: inputs a, b and DESCENDING; outputs lo, hi and swap.

Verification
REQ-028 The bench SHALL apply inputs 9,3,7,1 with start pulsed at edge E -> done at E+6, out0..out3 = 1,3,7,9, swap_count = 5.
REQ-029 The bench SHALL apply inputs 1,2,3,4 -> without the macro, done at E+6 with swap_count=0; with the macro, done at E+3.
REQ-030 The bench SHALL apply inputs 4,4,2,2 with DESCENDING=1 -> out = 4,4,2,2, swap_count = 0.
REQ-031 The bench SHALL apply inputs 15,0,15,0 -> out = 0,0,15,15, swap_count = 3.
REQ-032 The bench SHALL pulse start mid-sort and change the inputs -> the result reflects the originally captured values, and no second done pulse occurs.
REQ-033 The bench SHALL drive rst_n low at edge E+3 -> all outputs 0 and state IDLE immediately with no done pulse; a new start after release sorts correctly.

Source files
------------

// File: rtl/sort_pkg.sv
// sort_pkg: shared state encoding and sizing constants for the four-element bubble sorter
package sort_pkg;
  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
  localparam int NUM_ELEM = 4;
  localparam int PASS_W = 2;
  localparam int IDX_W = 2;
endpackage

// File: rtl/compare_swap.sv
// compare_swap: orders one adjacent pair; lo goes to the lower index, equal values stay put
module compare_swap #(
  parameter int W = 4,
  parameter bit DESCENDING = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swap
);
  assign swap = DESCENDING ? (a < b) : (a > b);
  assign lo = swap ? b : a;
  assign hi = swap ? a : b;
endmodule

// File: rtl/bubble_sorter.sv
// bubble_sorter: sequential bubble sort of four elements, one adjacent compare per cycle.
// Define BUBBLE_SORTER_EARLY_EXIT_EN to finish as soon as a whole pass makes no swaps.
module bubble_sorter
  import sort_pkg::*;
#(
  parameter int W = 4,
  parameter bit DESCENDING = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] first_reg,
  input  logic [W-1:0] second_reg,
  input  logic [W-1:0] third_reg,
  input  logic [W-1:0] fourth_reg,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3,
  output logic         busy,
  output logic         done,
  output logic [2:0]   swap_count
);
`ifdef BUBBLE_SORTER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  state_t state, state_n;
  logic [PASS_W-1:0] pass, pass_n;
  logic [IDX_W-1:0] idx, idx_n, nxt;
  logic [W-1:0] e [NUM_ELEM];
  logic [W-1:0] e_n [NUM_ELEM];
  logic [2:0] cnt, cnt_n;
  logic any, any_n, last;
  logic [W-1:0] lo, hi;
  logic sw;
  assign nxt = idx + 1'b1;
  compare_swap #(.W(W), .DESCENDING(DESCENDING)) u_cs (
    .a(e[idx]), .b(e[nxt]), .lo(lo), .hi(hi), .swap(sw)
  );
  assign last = (idx + pass) == 2'd2;
  always_comb begin
    state_n = state;
    pass_n = pass;
    idx_n = idx;
    e_n = e;
    cnt_n = cnt;
    any_n = any;
    if (state == IDLE) begin
      if (start) begin
        e_n = '{first_reg, second_reg, third_reg, fourth_reg};
        cnt_n = '0;
        pass_n = '0;
        idx_n = '0;
        any_n = 1'b0;
        state_n = COMPARE;
      end
    end else if (state == COMPARE) begin
      if (sw) begin
        e_n[idx] = lo;
        e_n[nxt] = hi;
        cnt_n = cnt + 3'd1;
      end
      any_n = any | sw;
      idx_n = nxt;
      if (last) begin
        pass_n = pass + 1'b1;
        idx_n = '0;
        any_n = 1'b0;
        state_n = (pass == 2'd2 || (EARLY && !(any | sw))) ? DONE : COMPARE;
      end
    end else begin
      pass_n = '0;
      idx_n = '0;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pass <= '0;
      idx <= '0;
      e <= '{default: '0};
      cnt <= '0;
      any <= 1'b0;
    end else begin
      state <= state_n;
      pass <= pass_n;
      idx <= idx_n;
      e <= e_n;
      cnt <= cnt_n;
      any <= any_n;
    end
  end
  assign busy = state == COMPARE;
  assign done = state == DONE;
  assign {out0, out1, out2, out3} = {e[0], e[1], e[2], e[3]};
  assign swap_count = cnt;
endmodule

// File: tb/tb_bubble_sorter.sv
// tb_bubble_sorter: random and directed checks of ascending and descending sorters against a reference model
module tb_bubble_sorter;
`ifdef BUBBLE_SORTER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk = 0, rst_n = 0, start = 0;
  logic [3:0] r0 = 0, r1 = 0, r2 = 0, r3 = 0;
  logic [3:0] a0, a1, a2, a3, d0, d1, d2, d3;
  logic busy_a, done_a, busy_d, done_d;
  logic [2:0] sc_a, sc_d;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bubble_sorter #(.W(4), .DESCENDING(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .first_reg(r0), .second_reg(r1), .third_reg(r2), .fourth_reg(r3),
    .out0(a0), .out1(a1), .out2(a2), .out3(a3),
    .busy(busy_a), .done(done_a), .swap_count(sc_a));

  bubble_sorter #(.W(4), .DESCENDING(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(start),
    .first_reg(r0), .second_reg(r1), .third_reg(r2), .fourth_reg(r3),
    .out0(d0), .out1(d1), .out2(d2), .out3(d3),
    .busy(busy_d), .done(done_d), .swap_count(sc_d));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  function automatic bit ooo(input logic [3:0] x, input logic [3:0] y, input int dsc);
    return dsc != 0 ? (x < y) : (x > y);
  endfunction

  // Model phase per instance: 0 idle, 1 sorting (m_rem cycles left), 2 done pulse
  int m_st [2], m_rem [2], m_cnt [2], p_cnt [2];
  logic [3:0] m_out [2][4];
  logic [3:0] p_out [2][4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_st[k] = 0; m_rem[k] = 0; m_cnt[k] = 0;
        for (int i = 0; i < 4; i++) m_out[k][i] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_st[k] == 0) begin
          if (start) begin
            logic [3:0] v [4];
            logic [3:0] t;
            int c, n;
            bit s, go;
            v = '{r0, r1, r2, r3};
            c = 0; n = 0; go = 1;
            for (int p = 0; p < 3; p++) begin
              if (go) begin
                s = 0;
                for (int i = 0; i <= 2 - p; i++) begin
                  n++;
                  if (ooo(v[i], v[i+1], k)) begin
                    t = v[i]; v[i] = v[i+1]; v[i+1] = t;
                    s = 1; c++;
                  end
                end
                if (EARLY && !s) go = 0;
              end
            end
            for (int i = 0; i < 4; i++) p_out[k][i] = v[i];
            p_cnt[k] = c;
            m_rem[k] = n;
            m_st[k] = 1;
          end
        end else if (m_st[k] == 1) begin
          m_rem[k]--;
          if (m_rem[k] == 0) begin
            m_st[k] = 2;
            m_out[k] = p_out[k];
            m_cnt[k] = p_cnt[k];
          end
        end else m_st[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy_a", busy_a, m_st[0] == 1);
    chk("done_a", done_a, m_st[0] == 2);
    chk("busy_d", busy_d, m_st[1] == 1);
    chk("done_d", done_d, m_st[1] == 2);
    if (m_st[0] != 1) begin
      chk("out_a", {a0, a1, a2, a3}, {m_out[0][0], m_out[0][1], m_out[0][2], m_out[0][3]});
      chk("cnt_a", sc_a, m_cnt[0]);
    end
    if (m_st[1] != 1) begin
      chk("out_d", {d0, d1, d2, d3}, {m_out[1][0], m_out[1][1], m_out[1][2], m_out[1][3]});
      chk("cnt_d", sc_d, m_cnt[1]);
    end
  end

  task automatic wait_done(input bit d, input string nm, output int lat);
    bit got = 0;
    lat = -1;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (d ? done_d : done_a) begin got = 1; lat = t; end
    end
    chk({nm, "_timeout"}, got, 1);
  endtask

  task automatic run(input logic [3:0] i0, i1, i2, i3, input bit d,
                     input logic [3:0] e0, e1, e2, e3, input int ec, el, input string nm);
    int lat;
    @(posedge clk); #1;
    {r0, r1, r2, r3} = {i0, i1, i2, i3};
    start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done(d, nm, lat);
    chk({nm, "_lat"}, lat, el);
    chk({nm, "_out"}, d ? {d0, d1, d2, d3} : {a0, a1, a2, a3}, {e0, e1, e2, e3});
    chk({nm, "_cnt"}, d ? sc_d : sc_a, ec);
    repeat (10) @(posedge clk);
  endtask

  initial begin
    int lat, t1, t2, pulses;
    #1;
    chk("rst_out", {a0, a1, a2, a3, d0, d1, d2, d3}, 0);
    chk("rst_flags", {busy_a, done_a, sc_a, busy_d, done_d, sc_d}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    run(9, 3, 7, 1, 0, 1, 3, 7, 9, 5, 6, "sort9371");
    run(1, 2, 3, 4, 0, 1, 2, 3, 4, 0, EARLY ? 3 : 6, "sorted");
    run(4, 4, 2, 2, 1, 4, 4, 2, 2, 0, EARLY ? 3 : 6, "desc4422");
    run(15, 0, 15, 0, 0, 0, 0, 15, 15, 3, 6, "sort15_0");
    // Mid-sort start with altered inputs must be ignored
    @(posedge clk); #1;
    {r0, r1, r2, r3} = {4'd8, 4'd6, 4'd4, 4'd2};
    start = 1;
    @(posedge clk); #1 start = 0;
    repeat (2) @(posedge clk);
    #1 {r0, r1, r2, r3} = 16'h0; start = 1;
    @(posedge clk); #1 start = 0;
    wait_done(0, "midsort", lat);
    chk("midsort_out", {a0, a1, a2, a3}, {4'd2, 4'd4, 4'd6, 4'd8});
    chk("midsort_cnt", sc_a, 6);
    pulses = 0;
    repeat (12) begin @(negedge clk); pulses += done_a; end
    chk("midsort_extra_done", pulses, 0);
    // Reset three edges into a sort
    @(posedge clk); #1;
    {r0, r1, r2, r3} = {4'd9, 4'd3, 4'd7, 4'd1};
    start = 1;
    @(posedge clk); #1 start = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("midrst_out", {a0, a1, a2, a3, d0, d1, d2, d3}, 0);
    chk("midrst_flags", {busy_a, done_a, sc_a, busy_d, done_d, sc_d}, 0);
    @(posedge clk); #1 rst_n = 1;
    run(9, 3, 7, 1, 0, 1, 3, 7, 9, 5, 6, "after_rst");
    // Continuous start gives an 8-cycle period
    @(posedge clk); #1;
    {r0, r1, r2, r3} = {4'd5, 4'd1, 4'd4, 4'd2};
    start = 1;
    t1 = -1; t2 = -1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (done_a) begin
        if (t1 < 0) t1 = t;
        else if (t2 < 0) t2 = t;
      end
    end
    chk("b2b_period", t2 - t1, 8);
    #1 start = 0;
    repeat (10) @(posedge clk);
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      start = ($urandom % 3) == 0;
      if ($urandom % 2) {r0, r1, r2, r3} = 16'($urandom);
      if (($urandom % 400) == 0) begin
        rst_n = 0;
        #2 rst_n = 1;
      end
    end
    start = 0;
    repeat (10) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
